// File: rtl/sub8u_pkg.sv
// Shared constants and types for the bit-serial unsigned subtractor.
package sub8u_pkg;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int SUB8U_WIDTH = 8;
   localparam int SUB8U_CNT_W = cnt_width(SUB8U_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub8u_serial_fsub1.sv
// One-bit full subtractor built only from gate primitives: diff = x - y - bin.
module fsub1 (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic x_xor_y;
   logic x_n;
   logic xy_n;
   logic brw_gen;
   logic brw_prop;

   xor g_xy   (x_xor_y, x, y);
   xor g_diff (diff, x_xor_y, bin);
   not g_xn   (x_n, x);
   and g_gen  (brw_gen, x_n, y);
   // Incoming borrow ripples through only when x and y are equal.
   not g_xyn  (xy_n, x_xor_y);
   and g_prop (brw_prop, xy_n, bin);
   or  g_bout (bout, brw_gen, brw_prop);

endmodule

// File: rtl/sub8u_serial.sv
// Recovers an addend from a sum word by LSB-first bit-serial subtraction, d = s - a.
module sub8u_serial
   import sub8u_pkg::*;
#(
   parameter int WIDTH = SUB8U_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             borrow,
   output logic             range_err
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH:0]   s_q, s_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH:0]   res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bor_q, bor_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             borrow_q, borrow_d;
   logic             range_err_q, range_err_d;
   logic             diff_bit;
   logic             bout_bit;

   // Operands are shifted right each bit, so the subtractor always sees bit 0.
   fsub1 u_fsub1 (
      .x    (s_q[0]),
      .y    (a_q[0]),
      .bin  (bor_q),
      .diff (diff_bit),
      .bout (bout_bit)
   );

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      a_d         = a_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      bor_d       = bor_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      d_d         = d_q;
      borrow_d    = borrow_q;
      range_err_d = range_err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               s_d        = s;
               a_d        = {1'b0, a};
               res_d      = '0;
               cnt_d      = '0;
               bor_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            s_d   = {1'b0, s_q[WIDTH:1]};
            a_d   = {1'b0, a_q[WIDTH:1]};
            res_d = {diff_bit, res_q[WIDTH:1]};
            bor_d = bout_bit;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               cnt_d       = '0;
               out_valid_d = 1'b1;
               d_d         = res_d[WIDTH-1:0];
               borrow_d    = bout_bit;
               range_err_d = diff_bit & ~bout_bit;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         a_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         bor_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         d_q         <= '0;
         borrow_q    <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         a_q         <= a_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         bor_q       <= bor_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         borrow_q    <= borrow_d;
         range_err_q <= range_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign borrow    = borrow_q;
   assign range_err = range_err_q;

endmodule

// File: doc/sub8u_serial.md
SUB8U_SERIAL -- requirements
Module: sub8u_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the addend width; the sum operand is WIDTH+1 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port s, input, WIDTH+1, unsigned sum word in adder output order (s[WIDTH] = carry-out).
REQ-007 SHALL have port a, input, WIDTH, unsigned known addend.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port d, output, WIDTH, recovered addend = (s - a) mod 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1, set when s < a.
REQ-012 SHALL have port range_err, output, 1, set when s - a >= 2^WIDTH with no borrow.

Function
REQ-013 SHALL compute R = s - zero-extended a over WIDTH+1 bits, bit-serially, LSB first, one bit per clock.
REQ-014 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL assert in_ready only in IDLE; an in_valid&&in_ready edge captures s and a, clears the borrow flop, loads bit counter to 0 and enters RUN.
REQ-016 SHALL in RUN process bit k = counter per edge with a 1-bit full subtractor, shifting the difference bit into a WIDTH+1 result register, and SHALL leave RUN after WIDTH+1 edges.
REQ-017 SHALL enter DONE on the edge that processes bit WIDTH; out_valid SHALL be high from the next cycle, i.e. WIDTH+1 cycles after the capture edge.
REQ-018 SHALL drive d = R[WIDTH-1:0], borrow = final borrow, range_err = R[WIDTH] & ~borrow; all three stable while out_valid is high.
REQ-019 SHALL hold DONE with outputs constant while out_ready is low (no result loss under backpressure).
REQ-020 SHALL return to IDLE on an out_valid&&out_ready edge and clear out_valid; no new capture on that same edge.
REQ-021 SHALL ignore in_valid and input data changes outside IDLE.
REQ-022 SHALL treat s = a as d = 0, borrow = 0, range_err = 0; s = 0, a = 0 likewise.

Reset
REQ-023 SHALL on rst high at any edge, including mid-RUN or in DONE, abort the operation and enter IDLE.
REQ-024 SHALL reset out_valid = 0, d = 0, borrow = 0, range_err = 0, in_ready = 1 (the cycle after reset deasserts), counter = 0, internal borrow = 0.
REQ-025 SHALL give rst priority over all handshakes on the same edge.

Structure
REQ-026 SHALL place WIDTH default constant, counter width constant clog2(WIDTH+1), and the state enumerated type in shared package sub8u_pkg.
REQ-027 SHALL instantiate one sub-module fsub1 (inputs x, y, bin; outputs diff, bout), one instance in the serial datapath.
REQ-028 SHALL use gate-level-mappable primitives only in fsub1 so its fault-resilience can be analysed like the team's adder netlists.

Verification
REQ-029 SHALL cover s=0x12C, a=0x64 -> after 9 cycles d=0xC8, borrow=0, range_err=0.
REQ-030 SHALL cover s=0x005, a=0x0A -> d=0xFB, borrow=1, range_err=0.
REQ-031 SHALL cover s=0x1FF, a=0x00 -> d=0xFF, borrow=0, range_err=1; and s=0x1FE, a=0xFF -> d=0xFF, flags 0.
REQ-032 SHALL cover out_ready held low 20 cycles after result -> out_valid and d unchanged, in_ready low throughout; release -> IDLE next cycle.
REQ-033 SHALL cover rst asserted at RUN bit 4 -> next cycle out_valid=0, d=0, in_ready=1; following op s=0x100, a=0x01 -> d=0xFF, flags 0.
REQ-034 SHALL cover random exhaustive loop: for all a, b in 0..255, s = a+b -> d=b, borrow=0, range_err=0.
